imem_arbiter: RTL

Shares the single-port synchronous instruction memory between the pipeline fetch stage and the debug/program-loader port. Fetch wins by default. A starvation counter and a lock mode give the debug port guaranteed access. Read data returns with a fixed 1-cycle latency and is steered back to the requester that was granted. The block sits between the IF stage / debug module and the instruction RAM array.

---
 rtl/imem_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Arbitrates the single-port synchronous instruction memory between the
// pipeline fetch stage and the debug/program-loader port.
//
// Fetch wins by default. Debug is forced through in two cases:
//   - after STARVE_MAX consecutive denied cycles (starvation counter), or
//   - while it holds the lock (LOCKED state).
// Read data returns one cycle after the grant. It is steered to whichever
// requester was granted, using a registered {valid, owner} tag.
//
// Optional feature: define IMEM_ARB_WRITE_EN to enable debug writes.
// With the macro undefined, the debug port is read-only:
//   - i_d_we is ignored,
//   - o_m_we is 0,
//   - o_m_wdata is 0.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_f_req/i_f_addr          fetch read request, byte address
//   o_f_gnt                   fetch accepted this cycle
//   o_f_rvalid/o_f_rdata      fetch read return (cycle after grant)
//   i_d_req/i_d_we/i_d_lock   debug request, write select, ownership lock
//   i_d_addr/i_d_wdata        debug byte address, write data
//   o_d_gnt                   debug accepted this cycle
//   o_d_rvalid/o_d_rdata      debug read return (cycle after grant)
//   o_m_en/o_m_we             memory enable / write enable
//   o_m_addr/o_m_wdata        memory word address / write data
//   i_m_rdata                 memory read data (cycle after read enable)
// -----------------------------------------------------------------------------
module imem_arbiter #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_f_req,
    input  logic [31:0]       i_f_addr,
    output logic              o_f_gnt,
    output logic              o_f_rvalid,
    output logic [31:0]       o_f_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic              i_d_lock,
    input  logic [31:0]       i_d_addr,
    input  logic [31:0]       i_d_wdata,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [31:0]       o_d_rdata,
    output logic              o_m_en,
    output logic              o_m_we,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [31:0]       o_m_wdata,
    input  logic [31:0]       i_m_rdata
);

    localparam int unsigned      CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               tag_vld_q, tag_vld_d;
    logic               tag_dbg_q, tag_dbg_d;

    logic               f_gnt, d_gnt;
    logic               d_we_eff;
    logic [31:0]        d_wdata_eff;
    logic [ADDR_W-1:0]  f_word, d_word;
    logic               unused_bits;

    assign f_word = i_f_addr[ADDR_W+1:2];
    assign d_word = i_d_addr[ADDR_W+1:2];

`ifdef IMEM_ARB_WRITE_EN
    assign d_we_eff    = i_d_we;
    assign d_wdata_eff = i_d_wdata;
    assign unused_bits = ^{i_f_addr[31:ADDR_W+2], i_f_addr[1:0],
                           i_d_addr[31:ADDR_W+2], i_d_addr[1:0]};
`else
    assign d_we_eff    = 1'b0;
    assign d_wdata_eff = '0;
    assign unused_bits = ^{i_f_addr[31:ADDR_W+2], i_f_addr[1:0],
                           i_d_addr[31:ADDR_W+2], i_d_addr[1:0],
                           i_d_we, i_d_wdata};
`endif

    // Grant / next-state logic. Reset suppresses all grants combinationally.
    always_comb begin
        f_gnt   = 1'b0;
        d_gnt   = 1'b0;
        state_d = state_q;
        wait_d  = wait_q;

        if (!i_rst) begin
            case (state_q)
                ST_ARB: begin
                    if (i_d_req && (!i_f_req || wait_q == CNT_MAX)) begin
                        d_gnt = 1'b1;
                    end else if (i_f_req) begin
                        f_gnt = 1'b1;
                    end
                    if (d_gnt && i_d_lock) begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // The lock-drop cycle still blocks fetch.
                    d_gnt = i_d_req;
                    if (!i_d_lock) begin
                        state_d = ST_ARB;
                    end
                end
                default: state_d = ST_ARB;
            endcase
        end

        // Starvation counter saturates at STARVE_MAX.
        if (!i_d_req || d_gnt) begin
            wait_d = '0;
        end else if (wait_q != CNT_MAX) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Memory drive
    assign o_f_gnt   = f_gnt;
    assign o_d_gnt   = d_gnt;
    assign o_m_en    = f_gnt | d_gnt;
    assign o_m_we    = d_gnt & d_we_eff;
    assign o_m_addr  = d_gnt ? d_word : (f_gnt ? f_word : '0);
    assign o_m_wdata = d_gnt ? d_wdata_eff : '0;

    // Return tag: one entry, overwritten on every cycle.
    assign tag_vld_d = o_m_en & ~o_m_we;
    assign tag_dbg_d = d_gnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_ARB;
            wait_q    <= '0;
            tag_vld_q <= 1'b0;
            tag_dbg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            tag_vld_q <= tag_vld_d;
            tag_dbg_q <= tag_dbg_d;
        end
    end

    assign o_f_rvalid = tag_vld_q & ~tag_dbg_q;
    assign o_d_rvalid = tag_vld_q &  tag_dbg_q;
    assign o_f_rdata  = o_f_rvalid ? i_m_rdata : '0;
    assign o_d_rdata  = o_d_rvalid ? i_m_rdata : '0;

endmodule
